// File: rtl/synth_pkg.sv
// synth_pkg: shared types and helpers for the synth voice path.
// Holds the allocator FSM state encoding, a clog2 helper and the default voice count.
package synth_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} state_e;
  localparam int DEF_CHANNELS = 16;
  function automatic int clog2(input int v);
    int r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction
endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: note event handshake between event source and allocator.
// valid/ready handshake; on = note-on (1) or note-off (0); key = note number; vel = velocity.
interface voice_allocator_if #(
  parameter int KEY_BITS = 7,
  parameter int VEL_BITS = 7
);
  logic                valid;
  logic                ready;
  logic                on;
  logic [KEY_BITS-1:0] key;
  logic [VEL_BITS-1:0] vel;
  modport master (output valid, on, key, vel, input ready);
  modport slave  (input valid, on, key, vel, output ready);
endinterface

// File: rtl/voice_age.sv
// voice_age: per-channel saturating age counters and oldest-channel search.
// Ports: clk, rst; bump_i ages all gated channels and zeroes target_i; gate_i current gates;
// oldest_o lowest-indexed channel holding the maximum age.
module voice_age import synth_pkg::*; #(
  parameter int NUM_CHANNELS = DEF_CHANNELS,
  parameter int AGE_BITS     = 8,
  parameter int IW           = clog2(DEF_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bump_i,
  input  logic [IW-1:0]           target_i,
  input  logic [NUM_CHANNELS-1:0] gate_i,
  output logic [IW-1:0]           oldest_o
);
  logic [AGE_BITS-1:0] age_q [NUM_CHANNELS];
  logic [AGE_BITS-1:0] best;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) age_q[i] <= '0;
    end else if (bump_i) begin
      for (int i = 0; i < NUM_CHANNELS; i++)
        age_q[i] <= (IW'(i) == target_i) ? '0 :
                    (gate_i[i] && age_q[i] != '1) ? age_q[i] + 1'b1 : age_q[i];
    end
  end
  // strict compare keeps the lowest index on ties
  always_comb begin
    oldest_o = '0;
    best     = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (age_q[i] > best) begin
        best     = age_q[i];
        oldest_o = IW'(i);
      end
  end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/off events to synth channels and drives gate/key/velocity.
// Ports: clk, rst; evt event handshake (slave); all_off_i panic; available_i envelope idle flags;
// gate_o held notes; trig_o envelope restart pulses; chan_key_o/chan_vel_o packed per-channel
// key and velocity; busy_o event in progress; steal_o pulse when a gated voice is taken.
module voice_allocator import synth_pkg::*; #(
  parameter int NUM_CHANNELS = DEF_CHANNELS,
  parameter int KEY_BITS     = 7,
  parameter int VEL_BITS     = 7,
  parameter int AGE_BITS     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  voice_allocator_if.slave                 evt,
  input  logic                             all_off_i,
  input  logic [NUM_CHANNELS-1:0]          available_i,
  output logic [NUM_CHANNELS-1:0]          gate_o,
  output logic [NUM_CHANNELS-1:0]          trig_o,
  output logic [KEY_BITS*NUM_CHANNELS-1:0] chan_key_o,
  output logic [VEL_BITS*NUM_CHANNELS-1:0] chan_vel_o,
  output logic                             busy_o,
  output logic                             steal_o
);
  localparam int IW = NUM_CHANNELS > 1 ? clog2(NUM_CHANNELS) : 1;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, match_q, free_q, rel_q, old_w, tgt;
  logic match_vld_q, free_vld_q, rel_vld_q, on_q;
  logic [KEY_BITS-1:0] ekey_q;
  logic [VEL_BITS-1:0] evel_q;
  logic [KEY_BITS-1:0] key_q [NUM_CHANNELS];
  logic [VEL_BITS-1:0] vel_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] gate_q, trig_q;
  logic steal_q, accept, do_on, do_off, last;
  assign evt.ready = state_q == IDLE && !all_off_i;
  assign accept    = evt.valid && evt.ready;
  assign last      = idx_q == IW'(NUM_CHANNELS - 1);
  always_comb begin
    state_d = state_q;
    state_d = all_off_i         ? IDLE :
              state_q == IDLE   ? (accept ? SCAN : IDLE) :
              state_q == SCAN   ? (last ? COMMIT : SCAN) : IDLE;
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // all_off aborts a pending COMMIT, so neither update path fires under it
  assign tgt    = match_vld_q ? match_q : free_vld_q ? free_q : rel_vld_q ? rel_q : old_w;
  assign do_on  = state_q == COMMIT && !all_off_i && on_q;
  assign do_off = state_q == COMMIT && !all_off_i && !on_q && match_vld_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      match_q     <= '0;
      free_q      <= '0;
      rel_q       <= '0;
      match_vld_q <= 1'b0;
      free_vld_q  <= 1'b0;
      rel_vld_q   <= 1'b0;
      on_q        <= 1'b0;
      ekey_q      <= '0;
      evel_q      <= '0;
    end else if (accept) begin
      idx_q       <= '0;
      match_vld_q <= 1'b0;
      free_vld_q  <= 1'b0;
      rel_vld_q   <= 1'b0;
      on_q        <= evt.on && |evt.vel;
      ekey_q      <= evt.key;
      evel_q      <= evt.vel;
    end else if (state_q == SCAN) begin
      idx_q <= idx_q + IW'(1);
      if (!match_vld_q && gate_q[idx_q] && key_q[idx_q] == ekey_q) begin
        match_vld_q <= 1'b1;
        match_q     <= idx_q;
      end
      if (!free_vld_q && !gate_q[idx_q] && available_i[idx_q]) begin
        free_vld_q <= 1'b1;
        free_q     <= idx_q;
      end
      if (!rel_vld_q && !gate_q[idx_q]) begin
        rel_vld_q <= 1'b1;
        rel_q     <= idx_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q  <= '0;
      trig_q  <= '0;
      steal_q <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        key_q[i] <= '0;
        vel_q[i] <= '0;
      end
    end else begin
      trig_q  <= '0;
      steal_q <= 1'b0;
      if (all_off_i) gate_q <= '0;
      else if (do_on) begin
        gate_q[tgt] <= 1'b1;
        key_q[tgt]  <= ekey_q;
        vel_q[tgt]  <= evel_q;
        trig_q[tgt] <= 1'b1;
        steal_q     <= !match_vld_q && !free_vld_q && !rel_vld_q;
      end else if (do_off) gate_q[match_q] <= 1'b0;
    end
  end
  voice_age #(.NUM_CHANNELS(NUM_CHANNELS), .AGE_BITS(AGE_BITS), .IW(IW)) u_age (
    .clk      (clk),
    .rst      (rst),
    .bump_i   (do_on),
    .target_i (tgt),
    .gate_i   (gate_q),
    .oldest_o (old_w)
  );
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pack
    assign chan_key_o[g*KEY_BITS +: KEY_BITS] = key_q[g];
    assign chan_vel_o[g*VEL_BITS +: VEL_BITS] = vel_q[g];
  end
  assign gate_o  = gate_q;
  assign trig_o  = trig_q;
  assign steal_o = steal_q;
  assign busy_o  = state_q != IDLE;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table-driven scoreboard bench for voice_allocator with 4 channels.
module tb_voice_allocator;
  localparam int N  = 4;
  localparam int KB = 7;
  localparam int VB = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic all_off = 1'b0;
  logic [N-1:0] available = '1;
  logic [N-1:0] gate, trig;
  logic [KB*N-1:0] chan_key;
  logic [VB*N-1:0] chan_vel;
  logic busy, steal;
  voice_allocator_if #(.KEY_BITS(KB), .VEL_BITS(VB)) evt ();
  voice_allocator #(.NUM_CHANNELS(N), .KEY_BITS(KB), .VEL_BITS(VB), .AGE_BITS(8)) dut (
    .clk(clk), .rst(rst), .evt(evt), .all_off_i(all_off), .available_i(available),
    .gate_o(gate), .trig_o(trig), .chan_key_o(chan_key), .chan_vel_o(chan_vel),
    .busy_o(busy), .steal_o(steal)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic          on;
    logic [KB-1:0] key;
    logic [VB-1:0] vel;
    logic [N-1:0]  avail;
    logic [N-1:0]  gate;
    logic [N-1:0]  trig;
    logic          steal;
    logic [KB*N-1:0] keys;
    logic [VB*N-1:0] vels;
  } vec_t;
  vec_t tbl [11];
  vec_t exp_q [$];
  int checks = 0;
  int errors = 0;
  function automatic logic [27:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction
  function automatic vec_t mk(input logic on, input int key, input int vel, input logic [3:0] av,
                              input logic [3:0] g, input logic [3:0] t, input logic st,
                              input logic [27:0] k, input logic [27:0] v);
    vec_t r;
    r.on = on; r.key = 7'(key); r.vel = 7'(vel); r.avail = av;
    r.gate = g; r.trig = t; r.steal = st; r.keys = k; r.vels = v;
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic collect();
    vec_t e;
    e = exp_q.pop_front();
    check("gate", 32'(gate), 32'(e.gate));
    check("trig", 32'(trig), 32'(e.trig));
    check("steal", 32'(steal), 32'(e.steal));
    check("chan_key", 32'(chan_key), 32'(e.keys));
    check("chan_vel", 32'(chan_vel), 32'(e.vels));
    check("ready_back", 32'(evt.ready), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
  endtask
  task automatic drive(input vec_t v);
    int n = 0;
    while (!evt.ready && n < 40) begin
      step(1);
      n++;
    end
    check("ready_wait", 32'(evt.ready), 32'd1);
    available = v.avail;
    evt.valid = 1'b1; evt.on = v.on; evt.key = v.key; evt.vel = v.vel;
    exp_q.push_back(v);
    step(1);
    evt.valid = 1'b0;
    check("busy_scan", 32'(busy), 32'd1);
    check("ready_low", 32'(evt.ready), 32'd0);
    step(N);
    check("trig_early", 32'(trig), 32'd0);
    step(1);
    collect();
    step(1);
    check("trig_once", 32'(trig), 32'd0);
    check("steal_once", 32'(steal), 32'd0);
    available = '1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic trig_seen;
    evt.valid = 1'b0; evt.on = 1'b0; evt.key = '0; evt.vel = '0;
    tbl[0]  = mk(1, 60, 100, 4'hF, 4'b0001, 4'b0001, 0, pk(0, 0, 0, 60),    pk(0, 0, 0, 100));
    tbl[1]  = mk(1, 62, 90,  4'hF, 4'b0011, 4'b0010, 0, pk(0, 0, 62, 60),   pk(0, 0, 90, 100));
    tbl[2]  = mk(1, 64, 80,  4'hF, 4'b0111, 4'b0100, 0, pk(0, 64, 62, 60),  pk(0, 80, 90, 100));
    tbl[3]  = mk(1, 66, 70,  4'hF, 4'b1111, 4'b1000, 0, pk(66, 64, 62, 60), pk(70, 80, 90, 100));
    tbl[4]  = mk(1, 67, 50,  4'hF, 4'b1111, 4'b0001, 1, pk(66, 64, 62, 67), pk(70, 80, 90, 50));
    tbl[5]  = mk(0, 64, 0,   4'hF, 4'b1011, 4'b0000, 0, pk(66, 64, 62, 67), pk(70, 80, 90, 50));
    tbl[6]  = mk(1, 70, 60,  4'hF, 4'b1111, 4'b0100, 0, pk(66, 70, 62, 67), pk(70, 60, 90, 50));
    tbl[7]  = mk(1, 62, 33,  4'hF, 4'b1111, 4'b0010, 0, pk(66, 70, 62, 67), pk(70, 60, 33, 50));
    tbl[8]  = mk(1, 62, 0,   4'hF, 4'b1101, 4'b0000, 0, pk(66, 70, 62, 67), pk(70, 60, 33, 50));
    tbl[9]  = mk(0, 99, 0,   4'hF, 4'b1101, 4'b0000, 0, pk(66, 70, 62, 67), pk(70, 60, 33, 50));
    tbl[10] = mk(1, 40, 20,  4'b1101, 4'b1111, 4'b0010, 0, pk(66, 70, 40, 67), pk(70, 60, 20, 50));
    step(2);
    rst = 1'b0;
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_steal", 32'(steal), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_key", 32'(chan_key), 32'd0);
    check("rst_vel", 32'(chan_vel), 32'd0);
    check("rst_ready", 32'(evt.ready), 32'd1);
    for (int i = 0; i < 11; i++) drive(tbl[i]);
    all_off = 1'b1;
    evt.valid = 1'b1; evt.on = 1'b1; evt.key = 7'd80; evt.vel = 7'd10;
    #1;
    check("alloff_ready", 32'(evt.ready), 32'd0);
    step(1);
    check("alloff_gate", 32'(gate), 32'd0);
    check("alloff_trig", 32'(trig), 32'd0);
    check("alloff_busy", 32'(busy), 32'd0);
    step(1);
    check("alloff_hold_ready", 32'(evt.ready), 32'd0);
    check("alloff_not_taken", 32'(busy), 32'd0);
    all_off = 1'b0;
    evt.valid = 1'b0;
    #1;
    check("alloff_release_ready", 32'(evt.ready), 32'd1);
    check("alloff_keys_kept", 32'(chan_key), 32'(pk(66, 70, 40, 67)));
    evt.valid = 1'b1; evt.on = 1'b1; evt.key = 7'd50; evt.vel = 7'd5;
    step(1);
    evt.valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    step(1);
    all_off = 1'b1;
    step(1);
    all_off = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    trig_seen = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      step(1);
      trig_seen = trig_seen | (|trig) | steal;
    end
    check("abort_no_trig", 32'(trig_seen), 32'd0);
    check("abort_gate", 32'(gate), 32'd0);
    check("abort_keys", 32'(chan_key), 32'(pk(66, 70, 40, 67)));
    drive(mk(1, 50, 5, 4'hF, 4'b0001, 4'b0001, 0, pk(66, 70, 40, 50), pk(70, 60, 20, 5)));
    evt.valid = 1'b1; evt.on = 1'b1; evt.key = 7'd51; evt.vel = 7'd9;
    step(1);
    evt.valid = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_gate", 32'(gate), 32'd0);
    check("midrst_key", 32'(chan_key), 32'd0);
    check("midrst_vel", 32'(chan_vel), 32'd0);
    check("midrst_trig", 32'(trig), 32'd0);
    check("midrst_ready", 32'(evt.ready), 32'd1);
    step(N + 3);
    check("midrst_no_commit", 32'(gate), 32'd0);
    drive(mk(1, 60, 100, 4'hF,    4'b0001, 4'b0001, 0, pk(0, 0, 0, 60),  pk(0, 0, 0, 100)));
    drive(mk(0, 60, 0,   4'b1110, 4'b0000, 4'b0000, 0, pk(0, 0, 0, 60),  pk(0, 0, 0, 100)));
    drive(mk(1, 62, 1,   4'b1110, 4'b0010, 4'b0010, 0, pk(0, 0, 62, 60), pk(0, 0, 1, 100)));
    drive(mk(1, 60, 0,   4'hF,    4'b0010, 4'b0000, 0, pk(0, 0, 62, 60), pk(0, 0, 1, 100)));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
